// File: rtl/sram_bist_pkg.sv
// Shared types and helpers for the single-port SRAM March C- BIST controller.
package sram_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_DRAIN,
    ST_DONE
  } march_state_e;

  typedef enum logic {
    PH_RD,
    PH_WR
  } op_phase_e;

  // Background bits; replicated to the core data width where used.
  localparam logic PAT0 = 1'b0;
  localparam logic PAT1 = 1'b1;

  function automatic logic is_desc(input march_state_e s);
    return (s == ST_M3) || (s == ST_M4);
  endfunction

  function automatic logic has_rw(input march_state_e s);
    return (s == ST_M1) || (s == ST_M2) || (s == ST_M3) || (s == ST_M4);
  endfunction

  function automatic logic rd_bg(input march_state_e s);
    return ((s == ST_M2) || (s == ST_M4)) ? PAT1 : PAT0;
  endfunction

  function automatic logic wr_bg(input march_state_e s);
    return ((s == ST_M1) || (s == ST_M3)) ? PAT1 : PAT0;
  endfunction

  function automatic march_state_e next_elem(input march_state_e s);
    case (s)
      ST_M0:   return ST_M1;
      ST_M1:   return ST_M2;
      ST_M2:   return ST_M3;
      ST_M3:   return ST_M4;
      ST_M4:   return ST_M5;
      ST_M5:   return ST_DRAIN;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// One-deep read-compare stage with sticky fail flag, first-fail address and
// saturating mismatch counter.
module sram_bist_cmp #(
  parameter int DW = 24,
  parameter int AW = 14,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          flush,
  input  logic          rd_issue,
  input  logic [DW-1:0] rd_exp,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] dout,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [EW-1:0] err_cnt
);

  localparam logic [EW-1:0] CNT_ONE = EW'(1);

  logic          pend_valid;
  logic [DW-1:0] pend_exp;
  logic [AW-1:0] pend_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_exp   <= '0;
      pend_addr  <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      err_cnt    <= '0;
    end else if (clear) begin
      pend_valid <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      err_cnt    <= '0;
    end else if (flush) begin
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= rd_issue;
      pend_exp   <= rd_exp;
      pend_addr  <= rd_addr;
      // Core output is registered: dout now reflects the read issued last cycle.
      if (pend_valid && (dout != pend_exp)) begin
        fail <= 1'b1;
        if (!fail) fail_addr <= pend_addr;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/sram_1p_bist_ctrl.sv
// March C- BIST controller and functional/BIST port mux in front of a
// single-port SRAM core with registered read data.
module sram_1p_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH    = 24,
  parameter int P_ADDR_WIDTH    = 14,
  parameter int P_ERR_CNT_WIDTH = 8
) (
  input  logic                       A_CLK,
  input  logic                       A_RESET_N,
  input  logic                       BIST_EN,
  input  logic                       BIST_START,
  input  logic [P_ADDR_WIDTH-1:0]    F_ADDR,
  input  logic [P_DATA_WIDTH-1:0]    F_DIN,
  input  logic                       F_MEN,
  input  logic                       F_WEN,
  input  logic                       F_REN,
  output logic [P_ADDR_WIDTH-1:0]    M_ADDR,
  output logic [P_DATA_WIDTH-1:0]    M_DIN,
  output logic                       M_MEN,
  output logic                       M_WEN,
  output logic                       M_REN,
  input  logic [P_DATA_WIDTH-1:0]    M_DOUT,
  output logic                       BIST_BUSY,
  output logic                       BIST_DONE,
  output logic                       BIST_FAIL,
  output logic [P_ADDR_WIDTH-1:0]    BIST_FAIL_ADDR,
  output logic [P_ERR_CNT_WIDTH-1:0] BIST_ERR_CNT
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE  = P_ADDR_WIDTH'(1);

  march_state_e              state;
  op_phase_e                 phase;
  logic [P_ADDR_WIDTH-1:0]   addr;
  logic                      busy;
  logic                      done;
  logic                      accept;
  logic                      abort;
  logic                      last_addr;
  logic                      op_rd;
  logic                      op_wr;
  march_state_e              nxt;

  assign accept    = BIST_EN && BIST_START && ((state == ST_IDLE) || (state == ST_DONE));
  assign abort     = busy && !BIST_EN;
  assign last_addr = is_desc(state) ? (addr == '0) : (addr == ADDR_LAST);
  assign nxt       = next_elem(state);
  assign BIST_BUSY = busy;
  assign BIST_DONE = done;

  always_comb begin
    op_rd = 1'b0;
    op_wr = 1'b0;
    case (state)
      ST_M0: op_wr = 1'b1;
      ST_M1, ST_M2, ST_M3, ST_M4: begin
        op_rd = (phase == PH_RD);
        op_wr = (phase == PH_WR);
      end
      ST_M5: op_rd = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    if (!BIST_EN) begin
      M_ADDR = F_ADDR;
      M_DIN  = F_DIN;
      M_MEN  = F_MEN;
      M_WEN  = F_WEN;
      M_REN  = F_REN;
    end else begin
      M_ADDR = (op_rd || op_wr) ? addr : '0;
      M_DIN  = op_wr ? {P_DATA_WIDTH{wr_bg(state)}} : '0;
      M_MEN  = op_rd || op_wr;
      M_WEN  = op_wr;
      M_REN  = op_rd;
    end
  end

  always_ff @(posedge A_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      state <= ST_IDLE;
      phase <= PH_RD;
      addr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (accept) begin
      state <= ST_M0;
      phase <= PH_RD;
      addr  <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
      phase <= PH_RD;
      addr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
          if (has_rw(state) && (phase == PH_RD)) begin
            phase <= PH_WR;
          end else begin
            phase <= PH_RD;
            if (last_addr) begin
              state <= nxt;
              addr  <= is_desc(nxt) ? ADDR_LAST : '0;
            end else begin
              addr <= is_desc(state) ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
            end
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sram_bist_cmp #(
    .DW (P_DATA_WIDTH),
    .AW (P_ADDR_WIDTH),
    .EW (P_ERR_CNT_WIDTH)
  ) u_cmp (
    .clk       (A_CLK),
    .rst_n     (A_RESET_N),
    .clear     (accept),
    .flush     (abort),
    .rd_issue  (op_rd && BIST_EN),
    .rd_exp    ({P_DATA_WIDTH{rd_bg(state)}}),
    .rd_addr   (addr),
    .dout      (M_DOUT),
    .fail      (BIST_FAIL),
    .fail_addr (BIST_FAIL_ADDR),
    .err_cnt   (BIST_ERR_CNT)
  );

endmodule

// File: tb/tb_sram_1p_bist_ctrl.sv
// Directed bench for sram_1p_bist_ctrl with a 16-word registered-read core model.
module tb_sram_1p_bist_ctrl;

  localparam int DW = 24;
  localparam int AW = 4;
  localparam int EW = 3;

  logic          A_CLK = 1'b0;
  logic          A_RESET_N = 1'b0;
  logic          BIST_EN = 1'b1;
  logic          BIST_START = 1'b0;
  logic [AW-1:0] F_ADDR = '0;
  logic [DW-1:0] F_DIN = '0;
  logic          F_MEN = 1'b0;
  logic          F_WEN = 1'b0;
  logic          F_REN = 1'b0;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DIN;
  logic          M_MEN, M_WEN, M_REN;
  logic [DW-1:0] M_DOUT;
  logic          BIST_BUSY, BIST_DONE, BIST_FAIL;
  logic [AW-1:0] BIST_FAIL_ADDR;
  logic [EW-1:0] BIST_ERR_CNT;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  int ncyc;

  always #5 A_CLK = ~A_CLK;

  sram_1p_bist_ctrl #(
    .P_DATA_WIDTH    (DW),
    .P_ADDR_WIDTH    (AW),
    .P_ERR_CNT_WIDTH (EW)
  ) dut (
    .A_CLK          (A_CLK),
    .A_RESET_N      (A_RESET_N),
    .BIST_EN        (BIST_EN),
    .BIST_START     (BIST_START),
    .F_ADDR         (F_ADDR),
    .F_DIN          (F_DIN),
    .F_MEN          (F_MEN),
    .F_WEN          (F_WEN),
    .F_REN          (F_REN),
    .M_ADDR         (M_ADDR),
    .M_DIN          (M_DIN),
    .M_MEN          (M_MEN),
    .M_WEN          (M_WEN),
    .M_REN          (M_REN),
    .M_DOUT         (M_DOUT),
    .BIST_BUSY      (BIST_BUSY),
    .BIST_DONE      (BIST_DONE),
    .BIST_FAIL      (BIST_FAIL),
    .BIST_FAIL_ADDR (BIST_FAIL_ADDR),
    .BIST_ERR_CNT   (BIST_ERR_CNT)
  );

  // Core model: mode 1 = bit0 stuck-at-1 at address 5, mode 2 = every read inverted.
  logic [DW-1:0] mem [16];
  always @(posedge A_CLK) begin
    if (M_MEN && M_WEN) mem[M_ADDR] <= M_DIN;
    if (M_MEN && M_REN) begin
      if (fault_mode == 1 && M_ADDR == 4'd5) M_DOUT <= mem[M_ADDR] | 24'h1;
      else if (fault_mode == 2)              M_DOUT <= ~mem[M_ADDR];
      else                                   M_DOUT <= mem[M_ADDR];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses START, then counts BUSY cycles (bounded) with optional sequence probes.
  task automatic run_bist(input bit probe, output int n);
    n = 0;
    @(negedge A_CLK); BIST_START = 1'b1;
    @(negedge A_CLK); BIST_START = 1'b0;
    while (BIST_BUSY === 1'b1 && n < 400) begin
      if (probe && n == 0) begin
        check("first_wr_addr", 32'(M_ADDR), 32'd0);
        check("first_wr_din",  32'(M_DIN),  32'h0);
        check("first_wr_wen",  32'(M_WEN),  32'd1);
      end
      if (probe && n == 80) begin
        check("m3_first_addr", 32'(M_ADDR), 32'd15);
        check("m3_first_ren",  32'(M_REN),  32'd1);
      end
      if (probe && n == 160) check("drain_men", 32'(M_MEN), 32'd0);
      n++;
      @(negedge A_CLK);
    end
  endtask

  initial begin
    #2;
    check("rst_busy",  32'(BIST_BUSY), 32'd0);
    check("rst_done",  32'(BIST_DONE), 32'd0);
    check("rst_fail",  32'(BIST_FAIL), 32'd0);
    check("rst_faddr", 32'(BIST_FAIL_ADDR), 32'd0);
    check("rst_ecnt",  32'(BIST_ERR_CNT), 32'd0);
    check("rst_men",   32'(M_MEN), 32'd0);
    @(negedge A_CLK); A_RESET_N = 1'b1;

    // Functional pass-through
    @(negedge A_CLK);
    BIST_EN = 1'b0; F_ADDR = 4'h3; F_DIN = 24'hA5A5A5; F_WEN = 1'b1; F_MEN = 1'b1;
    #1;
    check("pt_addr", 32'(M_ADDR), 32'h3);
    check("pt_din",  32'(M_DIN),  32'hA5A5A5);
    check("pt_men",  32'(M_MEN),  32'd1);
    check("pt_wen",  32'(M_WEN),  32'd1);
    check("pt_ren",  32'(M_REN),  32'd0);
    @(negedge A_CLK); BIST_START = 1'b1;
    @(negedge A_CLK); BIST_START = 1'b0;
    check("pt_start_ignored", 32'(BIST_BUSY), 32'd0);
    F_WEN = 1'b0; F_MEN = 1'b0;

    // BIST-owned idle: core held quiet
    BIST_EN = 1'b1; #1;
    check("idle_men",  32'(M_MEN),  32'd0);
    check("idle_addr", 32'(M_ADDR), 32'd0);

    // Fault-free run
    run_bist(1'b1, ncyc);
    check("clean_busy_cycles", 32'(ncyc), 32'd161);
    check("clean_done", 32'(BIST_DONE), 32'd1);
    check("clean_fail", 32'(BIST_FAIL), 32'd0);
    check("clean_ecnt", 32'(BIST_ERR_CNT), 32'd0);

    // Stuck-at-1 on bit0 of address 5: r0 in M1, M3, M5 all fail
    fault_mode = 1;
    run_bist(1'b0, ncyc);
    check("sa1_busy_cycles", 32'(ncyc), 32'd161);
    check("sa1_done",  32'(BIST_DONE), 32'd1);
    check("sa1_fail",  32'(BIST_FAIL), 32'd1);
    check("sa1_faddr", 32'(BIST_FAIL_ADDR), 32'd5);
    check("sa1_ecnt",  32'(BIST_ERR_CNT), 32'd3);

    // Every read wrong: counter saturates, first failure at M1 address 0
    fault_mode = 2;
    run_bist(1'b0, ncyc);
    check("sat_fail",  32'(BIST_FAIL), 32'd1);
    check("sat_faddr", 32'(BIST_FAIL_ADDR), 32'd0);
    check("sat_ecnt",  32'(BIST_ERR_CNT), 32'd7);

    // Abort at cycle 50, then a full clean rerun
    fault_mode = 0;
    @(negedge A_CLK); BIST_START = 1'b1;
    @(negedge A_CLK); BIST_START = 1'b0;
    repeat (49) @(negedge A_CLK);
    check("abort_pre_busy", 32'(BIST_BUSY), 32'd1);
    BIST_EN = 1'b0;
    @(posedge A_CLK); #1;
    check("abort_busy", 32'(BIST_BUSY), 32'd0);
    check("abort_done", 32'(BIST_DONE), 32'd0);
    @(negedge A_CLK); BIST_EN = 1'b1;
    run_bist(1'b0, ncyc);
    check("rerun_busy_cycles", 32'(ncyc), 32'd161);
    check("rerun_done", 32'(BIST_DONE), 32'd1);
    check("rerun_fail", 32'(BIST_FAIL), 32'd0);

    // Asynchronous reset during M2 (cycles 48..79) after an M1 failure
    fault_mode = 1;
    @(negedge A_CLK); BIST_START = 1'b1;
    @(negedge A_CLK); BIST_START = 1'b0;
    repeat (55) @(negedge A_CLK);
    check("mid_fail_pre", 32'(BIST_FAIL), 32'd1);
    check("mid_men_pre",  32'(M_MEN), 32'd1);
    #2 A_RESET_N = 1'b0;
    #1;
    check("mid_rst_busy",  32'(BIST_BUSY), 32'd0);
    check("mid_rst_done",  32'(BIST_DONE), 32'd0);
    check("mid_rst_fail",  32'(BIST_FAIL), 32'd0);
    check("mid_rst_faddr", 32'(BIST_FAIL_ADDR), 32'd0);
    check("mid_rst_ecnt",  32'(BIST_ERR_CNT), 32'd0);
    check("mid_rst_men",   32'(M_MEN), 32'd0);
    @(negedge A_CLK); A_RESET_N = 1'b1;
    @(negedge A_CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
